// File: rtl/rate_generator_pkg.sv
// Shared types for the rate generator.
// Counter width, FSM states, drift direction.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH = 8;

  typedef logic [RATE_COUNTER_WIDTH-1:0] rate_t;

  localparam rate_t MIN_RATE = rate_t'(2);

  typedef enum logic {
    DRIFT_LEAD = 1'b0,
    DRIFT_LAG  = 1'b1
  } drift_direction_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } rate_gen_state_e;

endpackage

// File: rtl/rate_generator_if.sv
// Control and status bundle of the rate generator.
// master drives requests, slave is the generator side.
interface rate_generator_if;
  import clks_alot_p::*;

  logic             clk_en;
  logic             gen_en_i;
  logic             clear_state_i;
  logic             rate_valid_i;
  rate_t            rate_i;
  logic             drift_valid_i;
  drift_direction_e drift_direction_i;
  rate_t            drift_amount_i;

  logic             gen_clk_o;
  logic             rise_o;
  logic             fall_o;
  rate_t            active_rate_o;
  logic             running_o;
  logic             rate_error_o;

  modport master (
    output clk_en, gen_en_i, clear_state_i,
    output rate_valid_i, rate_i,
    output drift_valid_i, drift_direction_i,
    output drift_amount_i,
    input  gen_clk_o, rise_o, fall_o,
    input  active_rate_o, running_o,
    input  rate_error_o
  );

  modport slave (
    input  clk_en, gen_en_i, clear_state_i,
    input  rate_valid_i, rate_i,
    input  drift_valid_i, drift_direction_i,
    input  drift_amount_i,
    output gen_clk_o, rise_o, fall_o,
    output active_rate_o, running_o,
    output rate_error_o
  );

endinterface

// File: rtl/period_adjust.sv
// Saturating drift arithmetic for one period.
// LAG clamps at all-ones, LEAD clamps at MIN_RATE.
module period_adjust
  import clks_alot_p::*;
(
  input  rate_t            rate_i,
  input  drift_direction_e dir_i,
  input  rate_t            amount_i,
  output rate_t            period_o
);

  localparam int RW = RATE_COUNTER_WIDTH;

  logic [RW:0] sum;
  logic [RW:0] diff;

  always_comb begin
    sum      = {1'b0, rate_i} + {1'b0, amount_i};
    diff     = {1'b0, rate_i} - {1'b0, amount_i};
    period_o = rate_i;
    unique case (dir_i)
      DRIFT_LAG:
        period_o = sum[RW] ? '1 : sum[RW-1:0];
      DRIFT_LEAD:
        period_o = (diff[RW] || (diff[RW-1:0] < MIN_RATE))
                   ? MIN_RATE : diff[RW-1:0];
    endcase
  end

endmodule

// File: rtl/rate_generator.sv
// Programmable clock synthesizer with period-aligned
// rate changes and one-shot drift correction.
module rate_generator
  import clks_alot_p::*;
(
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             clk_en,
  input  logic             gen_en_i,
  input  logic             clear_state_i,
  input  logic             rate_valid_i,
  input  rate_t            rate_i,
  input  logic             drift_valid_i,
  input  drift_direction_e drift_direction_i,
  input  rate_t            drift_amount_i,
  output logic             gen_clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output rate_t            active_rate_o,
  output logic             running_o,
  output logic             rate_error_o
);

  rate_gen_state_e  state_q, state_d;
  rate_t            cnt_q, cnt_d;
  rate_t            per_q, per_d;
  rate_t            act_q, act_d;
  rate_t            prate_q, prate_d;
  logic             prate_vld_q, prate_vld_d;
  logic             drift_vld_q, drift_vld_d;
  drift_direction_e ddir_q, ddir_d;
  rate_t            damt_q, damt_d;
  logic             gen_q, gen_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             run_q, run_d;
  logic             err_q, err_d;
  logic             live_q, live_d;

  logic             go;
  logic             rate_ok;
  logic             rate_bad;
  logic             at_end;
  logic             d_vld;
  drift_direction_e d_dir;
  rate_t            d_amt;
  rate_t            nxt_base;
  rate_t            adj_per;
  rate_t            nxt_per;
  rate_t            cnt_inc;

  // Ignore the first edge after reset release.
  assign go       = clk_en & live_q;
  assign rate_ok  = rate_valid_i & (rate_i >= MIN_RATE);
  assign rate_bad = rate_valid_i & (rate_i < MIN_RATE);
  assign at_end   = (state_q == RUN)
                  && (cnt_q == per_q - rate_t'(1));
  assign cnt_inc  = cnt_q + rate_t'(1);

  // Same-cycle loads bypass the pending registers.
  assign nxt_base = rate_ok     ? rate_i  :
                    prate_vld_q ? prate_q : act_q;
  assign d_vld    = drift_vld_q
                  | (drift_valid_i & (state_q == RUN));
  assign d_dir    = drift_valid_i ? drift_direction_i
                                  : ddir_q;
  assign d_amt    = drift_valid_i ? drift_amount_i
                                  : damt_q;
  assign nxt_per  = d_vld ? adj_per : nxt_base;

  period_adjust u_adj (
    .rate_i   (nxt_base),
    .dir_i    (d_dir),
    .amount_i (d_amt),
    .period_o (adj_per)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    act_d       = act_q;
    prate_d     = prate_q;
    prate_vld_d = prate_vld_q;
    drift_vld_d = drift_vld_q;
    ddir_d      = ddir_q;
    damt_d      = damt_q;
    gen_d       = gen_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    err_d       = err_q;
    live_d      = 1'b1;
    if (go) begin
      if (clear_state_i) begin
        state_d     = IDLE;
        cnt_d       = '0;
        per_d       = '0;
        act_d       = '0;
        prate_d     = '0;
        prate_vld_d = 1'b0;
        drift_vld_d = 1'b0;
        ddir_d      = DRIFT_LEAD;
        damt_d      = '0;
        gen_d       = 1'b0;
        err_d       = 1'b0;
      end else begin
        if (rate_bad) err_d = 1'b1;
        unique case (state_q)
          IDLE: begin
            if (rate_ok) begin
              act_d   = rate_i;
              state_d = gen_en_i ? RUN : ARMED;
            end
          end
          ARMED: begin
            if (rate_ok) act_d = rate_i;
            if (gen_en_i) state_d = RUN;
          end
          RUN: begin
            if (at_end) begin
              act_d       = nxt_base;
              prate_vld_d = 1'b0;
              drift_vld_d = 1'b0;
              cnt_d       = '0;
              if (gen_en_i) begin
                per_d  = nxt_per;
                gen_d  = 1'b1;
                rise_d = 1'b1;
              end else begin
                state_d = ARMED;
                gen_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == (per_q >> 1)) begin
                gen_d  = 1'b0;
                fall_d = 1'b1;
              end
              if (rate_ok) begin
                prate_d     = rate_i;
                prate_vld_d = 1'b1;
              end
              if (drift_valid_i) begin
                drift_vld_d = 1'b1;
                ddir_d      = drift_direction_i;
                damt_d      = drift_amount_i;
              end
            end
          end
          default: state_d = IDLE;
        endcase
        if ((state_q != RUN) && (state_d == RUN)) begin
          cnt_d  = '0;
          per_d  = nxt_per;
          gen_d  = 1'b1;
          rise_d = 1'b1;
        end
      end
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      act_q       <= '0;
      prate_q     <= '0;
      prate_vld_q <= 1'b0;
      drift_vld_q <= 1'b0;
      ddir_q      <= DRIFT_LEAD;
      damt_q      <= '0;
      gen_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      run_q       <= 1'b0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      act_q       <= act_d;
      prate_q     <= prate_d;
      prate_vld_q <= prate_vld_d;
      drift_vld_q <= drift_vld_d;
      ddir_q      <= ddir_d;
      damt_q      <= damt_d;
      gen_q       <= gen_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      run_q       <= run_d;
      err_q       <= err_d;
      live_q      <= live_d;
    end
  end

  assign gen_clk_o     = gen_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  assign active_rate_o = act_q;
  assign running_o     = run_q;
  assign rate_error_o  = err_q;

endmodule

// File: tb/tb_rate_generator.sv
// Self-checking bench for rate_generator: vector table,
// directed period sequences and a randomized model run.
module tb_rate_generator;
  import clks_alot_p::*;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;

  rate_generator_if rif ();

  rate_generator dut (
    .clk               (clk),
    .async_rst_n       (async_rst_n),
    .clk_en            (rif.clk_en),
    .gen_en_i          (rif.gen_en_i),
    .clear_state_i     (rif.clear_state_i),
    .rate_valid_i      (rif.rate_valid_i),
    .rate_i            (rif.rate_i),
    .drift_valid_i     (rif.drift_valid_i),
    .drift_direction_i (rif.drift_direction_i),
    .drift_amount_i    (rif.drift_amount_i),
    .gen_clk_o         (rif.gen_clk_o),
    .rise_o            (rif.rise_o),
    .fall_o            (rif.fall_o),
    .active_rate_o     (rif.active_rate_o),
    .running_o         (rif.running_o),
    .rate_error_o      (rif.rate_error_o)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;
  int low_pulse;
  int rq[$];
  int fq[$];

  // Reference model: mode 0 idle, 1 armed, 2 running.
  int m_mode, m_ph, m_per, m_rate, m_pend, m_damt;
  bit m_live, m_dset, m_dlag;
  bit e_gen, e_rise, e_fall, e_err;

  typedef struct {
    logic en, gen, clr, rv;
    int   rate;
    logic x_rise, x_fall, x_gen, x_run, x_err;
    int   x_rate;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int adj(int base, bit lag, int amt);
    int p;
    if (lag) begin
      p = base + amt;
      if (p > 255) p = 255;
    end else begin
      p = base - amt;
      if (p < 2) p = 2;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_per = 0; m_rate = 0;
    m_pend = -1; m_damt = 0; m_dset = 0; m_dlag = 0;
    m_live = 0;
    e_gen = 0; e_rise = 0; e_fall = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit ok;
    e_rise = 0;
    e_fall = 0;
    if (!m_live) begin
      m_live = 1;
      return;
    end
    if (!rif.clk_en) return;
    if (rif.clear_state_i) begin
      m_mode = 0; m_ph = 0; m_per = 0; m_rate = 0;
      m_pend = -1; m_dset = 0; e_gen = 0; e_err = 0;
      return;
    end
    ok = rif.rate_valid_i && (int'(rif.rate_i) >= 2);
    if (rif.rate_valid_i && !ok) e_err = 1;
    if (m_mode != 2) begin
      if (ok) m_rate = int'(rif.rate_i);
      if (rif.gen_en_i && (m_mode == 1 || ok)) begin
        m_mode = 2; m_ph = 0; m_per = m_rate;
        e_gen = 1; e_rise = 1;
      end else if (ok) begin
        m_mode = 1;
      end
    end else begin
      if (ok) m_pend = int'(rif.rate_i);
      if (rif.drift_valid_i) begin
        m_dset = 1;
        m_dlag = (rif.drift_direction_i == DRIFT_LAG);
        m_damt = int'(rif.drift_amount_i);
      end
      if (m_ph == m_per - 1) begin
        if (m_pend >= 0) m_rate = m_pend;
        m_pend = -1;
        m_ph = 0;
        if (rif.gen_en_i) begin
          m_per = m_dset ? adj(m_rate, m_dlag, m_damt)
                         : m_rate;
          e_gen = 1; e_rise = 1;
        end else begin
          m_mode = 1; e_gen = 0;
        end
        m_dset = 0;
      end else begin
        m_ph++;
        if (m_ph == m_per / 2) begin
          e_fall = 1; e_gen = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("gen_clk",  rif.gen_clk_o,     e_gen);
    chk("rise",     rif.rise_o,        e_rise);
    chk("fall",     rif.fall_o,        e_fall);
    chk("running",  rif.running_o,     m_mode == 2);
    chk("rate_err", rif.rate_error_o,  e_err);
    chk("act_rate", rif.active_rate_o, m_rate);
    if (rif.rise_o) rq.push_back(cyc);
    if (rif.fall_o) fq.push_back(cyc);
    if (!rif.clk_en && (rif.rise_o || rif.fall_o))
      low_pulse++;
  endtask

  task automatic idle_in();
    rif.clk_en            = 1'b1;
    rif.gen_en_i          = 1'b0;
    rif.clear_state_i     = 1'b0;
    rif.rate_valid_i      = 1'b0;
    rif.rate_i            = '0;
    rif.drift_valid_i     = 1'b0;
    rif.drift_direction_i = DRIFT_LEAD;
    rif.drift_amount_i    = '0;
  endtask

  task automatic clear_seq();
    idle_in();
    rif.clear_state_i = 1'b1;
    tick();
    rif.clear_state_i = 1'b0;
    rq.delete();
    fq.delete();
    low_pulse = 0;
  endtask

  task automatic start(int rate);
    rif.rate_valid_i = 1'b1;
    rif.rate_i       = rate_t'(rate);
    rif.gen_en_i     = 1'b1;
    tick();
    rif.rate_valid_i = 1'b0;
  endtask

  task automatic wait_rises(int n, int budget);
    for (int i = 0; i < budget && rq.size() < n; i++)
      tick();
    chk("rise_budget", rq.size() >= n, 1);
  endtask

  task automatic drift_seq(int rate, drift_direction_e dir,
                           int amt, int exp_mid);
    clear_seq();
    start(rate);
    tick();
    rif.drift_valid_i     = 1'b1;
    rif.drift_direction_i = dir;
    rif.drift_amount_i    = rate_t'(amt);
    tick();
    rif.drift_valid_i = 1'b0;
    wait_rises(4, 2000);
    if (rq.size() >= 4) begin
      chk("drift_p0", rq[1] - rq[0], rate);
      chk("drift_p1", rq[2] - rq[1], exp_mid);
      chk("drift_p2", rq[3] - rq[2], rate);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; low_pulse = 0;
    tbl[0]  = '{1,0,0,1,1, 0,0,0,0,1,0};
    tbl[1]  = '{1,0,1,0,0, 0,0,0,0,0,0};
    tbl[2]  = '{1,0,0,1,4, 0,0,0,0,0,4};
    tbl[3]  = '{1,0,0,1,0, 0,0,0,0,1,4};
    tbl[4]  = '{1,1,0,0,0, 1,0,1,1,1,4};
    tbl[5]  = '{1,1,0,0,0, 0,0,1,1,1,4};
    tbl[6]  = '{1,1,0,0,0, 0,1,0,1,1,4};
    tbl[7]  = '{1,1,0,0,0, 0,0,0,1,1,4};
    tbl[8]  = '{1,1,0,0,0, 1,0,1,1,1,4};
    tbl[9]  = '{0,1,0,0,0, 0,0,1,1,1,4};
    tbl[10] = '{1,0,0,0,0, 0,0,1,1,1,4};
    tbl[11] = '{1,0,0,0,0, 0,1,0,1,1,4};
    tbl[12] = '{1,0,0,0,0, 0,0,0,1,1,4};
    tbl[13] = '{1,0,0,0,0, 0,0,0,0,1,4};
    tbl[14] = '{1,0,1,0,0, 0,0,0,0,0,0};
    tbl[15] = '{1,1,0,1,2, 1,0,1,1,0,2};
    tbl[16] = '{1,1,0,0,0, 0,1,0,1,0,2};
    tbl[17] = '{1,1,0,0,0, 1,0,1,1,0,2};
    tbl[18] = '{0,1,1,0,0, 0,0,1,1,0,2};
    tbl[19] = '{1,1,0,0,0, 0,1,0,1,0,2};

    idle_in();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen",  rif.gen_clk_o,     0);
    chk("rst_rise", rif.rise_o,        0);
    chk("rst_fall", rif.fall_o,        0);
    chk("rst_run",  rif.running_o,     0);
    chk("rst_err",  rif.rate_error_o,  0);
    chk("rst_rate", rif.active_rate_o, 0);
    async_rst_n = 1'b1;
    tick();
    tick();

    foreach (tbl[i]) begin
      idle_in();
      rif.clk_en        = tbl[i].en;
      rif.gen_en_i      = tbl[i].gen;
      rif.clear_state_i = tbl[i].clr;
      rif.rate_valid_i  = tbl[i].rv;
      rif.rate_i        = rate_t'(tbl[i].rate);
      tick();
      chk($sformatf("vec%0d_rise", i), rif.rise_o,
          tbl[i].x_rise);
      chk($sformatf("vec%0d_fall", i), rif.fall_o,
          tbl[i].x_fall);
      chk($sformatf("vec%0d_gen", i), rif.gen_clk_o,
          tbl[i].x_gen);
      chk($sformatf("vec%0d_run", i), rif.running_o,
          tbl[i].x_run);
      chk($sformatf("vec%0d_err", i), rif.rate_error_o,
          tbl[i].x_err);
      chk($sformatf("vec%0d_rate", i), rif.active_rate_o,
          tbl[i].x_rate);
    end

    // Rate 10: rise every 10, high 5 / low 5.
    clear_seq();
    start(10);
    wait_rises(3, 60);
    if (rq.size() >= 3 && fq.size() >= 2) begin
      chk("r10_period0", rq[1] - rq[0], 10);
      chk("r10_period1", rq[2] - rq[1], 10);
      chk("r10_high",    fq[1] - rq[1], 5);
      chk("r10_low",     rq[2] - fq[1], 5);
    end

    // Rate 7 with rate 4 loaded at count 3.
    clear_seq();
    start(7);
    repeat (3) tick();
    rif.rate_valid_i = 1'b1;
    rif.rate_i       = rate_t'(4);
    tick();
    rif.rate_valid_i = 1'b0;
    wait_rises(4, 40);
    if (rq.size() >= 4 && fq.size() >= 2) begin
      chk("chg_p0",   rq[1] - rq[0], 7);
      chk("chg_p1",   rq[2] - rq[1], 4);
      chk("chg_p2",   rq[3] - rq[2], 4);
      chk("chg_fall", fq[1] - rq[1], 2);
    end

    drift_seq(10,  DRIFT_LEAD, 3,  7);
    drift_seq(10,  DRIFT_LAG,  3,  13);
    drift_seq(10,  DRIFT_LEAD, 20, 2);
    drift_seq(250, DRIFT_LAG,  10, 255);

    // clk_en at 50% with rate 4.
    clear_seq();
    start(4);
    for (int i = 0; i < 40; i++) begin
      rif.clk_en = (i % 2 == 1);
      tick();
    end
    rif.clk_en = 1'b1;
    chk("en50_rises", rq.size() >= 3, 1);
    if (rq.size() >= 3 && fq.size() >= 1) begin
      chk("en50_p0",   rq[1] - rq[0], 8);
      chk("en50_p1",   rq[2] - rq[1], 8);
      chk("en50_fall", fq[0] - rq[0], 4);
    end
    chk("en50_low_pulses", low_pulse, 0);

    // Asynchronous reset mid-period at count 3.
    clear_seq();
    start(10);
    repeat (3) tick();
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("arst_gen",  rif.gen_clk_o,     0);
    chk("arst_rise", rif.rise_o,        0);
    chk("arst_fall", rif.fall_o,        0);
    chk("arst_run",  rif.running_o,     0);
    chk("arst_err",  rif.rate_error_o,  0);
    chk("arst_rate", rif.active_rate_o, 0);
    repeat (2) @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    model_reset();
    idle_in();
    rif.gen_en_i = 1'b1;
    rq.delete();
    fq.delete();
    repeat (8) tick();
    chk("arst_no_rise", rq.size(), 0);
    start(3);
    wait_rises(2, 20);
    if (rq.size() >= 2)
      chk("arst_resume", rq[1] - rq[0], 3);

    // Randomized traffic against the model.
    clear_seq();
    for (int i = 0; i < 800; i++) begin
      rif.clk_en        = ($urandom_range(0, 99) < 85);
      rif.gen_en_i      = ($urandom_range(0, 99) < 90);
      rif.clear_state_i = ($urandom_range(0, 99) < 2);
      rif.rate_valid_i  = ($urandom_range(0, 99) < 6);
      rif.rate_i        = rate_t'($urandom_range(0, 12));
      rif.drift_valid_i = ($urandom_range(0, 99) < 6);
      rif.drift_direction_i =
        drift_direction_e'($urandom_range(0, 1));
      rif.drift_amount_i = rate_t'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rate_generator.md
RATE_GENERATOR -- requirements
Module: rate_generator

Interface
REQ-001 SHALL have parameter none; widths SHALL come from clks_alot_p::RATE_COUNTER_WIDTH (RW below).
REQ-002 SHALL have ports: clk  input  1  sole clock, rising-edge; async_rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: clk_en  input  1  cycle qualifier, all state advances only when high; gen_en_i  input  1  run request; clear_state_i  input  1  abort to IDLE.
REQ-004 SHALL have ports: rate_valid_i  input  1  rate load strobe; rate_i  input  RW  period in qualified cycles.
REQ-005 SHALL have ports: drift_valid_i  input  1  one-shot correction strobe; drift_direction_i  input  clks_alot_p::drift_direction_e  LEAD shortens, LAG lengthens; drift_amount_i  input  RW  cycles.
REQ-006 SHALL have ports: gen_clk_o  output  1  synthesized clock level; rise_o / fall_o  output  1  one-cycle edge pulses; active_rate_o  output  RW  rate in use; running_o  output  1  RUN state; rate_error_o  output  1  sticky illegal-rate flag.

Function
REQ-007 SHALL implement states IDLE, ARMED (legal rate held, gen_en_i low), RUN.
REQ-008 IDLE->ARMED on qualified rate_valid_i with rate_i>=2; ARMED->RUN on qualified gen_en_i; IDLE->RUN directly if both in same qualified cycle.
REQ-009 RUN->ARMED when gen_en_i low at a period boundary (phase count = period-1); gen_clk_o SHALL never be truncated mid-period.
REQ-010 clear_state_i (qualified) SHALL force IDLE next cycle from any state, zero phase counter, drop gen_clk_o, discard pending rate/drift; clear_state_i wins over all other inputs.
REQ-011 Phase counter SHALL count 0..period-1 in RUN; at count 0 rise_o pulses and gen_clk_o goes 1; at count = period>>1 fall_o pulses and gen_clk_o goes 0.
REQ-012 First rise_o SHALL occur one clk after the qualified cycle entering RUN.
REQ-013 rate_valid_i in RUN SHALL update a pending register; new rate takes effect at the next count-0, never mid-period; latest load wins.
REQ-014 rate_i<2 SHALL be rejected (no state change) and set rate_error_o until clear_state_i or reset.
REQ-015 Qualified drift_valid_i in RUN SHALL modify only the next single period: LAG period = rate+amount saturating at all-ones; LEAD period = rate-amount saturating at 2; later periods revert to active_rate_o.
REQ-016 Drift and rate load in same cycle: new rate SHALL be the base for the drift-modified period; second drift before application SHALL replace the first.
REQ-017 Drift received in IDLE/ARMED SHALL be ignored.
REQ-018 With clk_en low, all state, counter and gen_clk_o SHALL hold; rise_o/fall_o SHALL be low.
REQ-019 rise_o/fall_o SHALL be high for exactly one clk and never simultaneously.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 async_rst_n low SHALL immediately set IDLE, counter 0, gen_clk_o 0, rise_o 0, fall_o 0, active_rate_o 0, running_o 0, rate_error_o 0, pending flags cleared.
REQ-022 Reset deassertion mid-operation SHALL resume from IDLE only; no edge pulse within the first clk after release.

Structure
REQ-023 State enum rate_gen_state_e SHALL live in clks_alot_p alongside RATE_COUNTER_WIDTH, drift_direction_e and a MIN_RATE=2 constant.
REQ-024 Saturating period arithmetic SHALL be one sub-module, period_adjust (combinational, RW in, RW out).

Verification
REQ-025 Load rate 10, gen_en 1, clk_en 1 -> rise_o every 10 clks, fall_o 5 clks after each rise, gen_clk_o high 5/low 5.
REQ-026 Rate 7 running, load 4 at count 3 -> current period completes at 7, then period 4 (fall at count 2).
REQ-027 Rate 10, LEAD 3 -> one 7-clk period then 10; LAG 3 -> one 13-clk period; LEAD 20 -> period 2.
REQ-028 Rate 1 loaded -> rate_error_o 1, state unchanged; clear_state_i -> rate_error_o 0, IDLE.
REQ-029 clk_en toggled 50% with rate 4 -> rise_o every 8 clks, no pulse in low-clk_en cycles.
REQ-030 async_rst_n low mid-RUN at count 3 -> all outputs 0 same cycle; after release, no rise_o until new rate+gen_en.
